// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the shared byte FIFO.
// Producers take bounded tenures of up to MAX_BURST beats. Each tenure is
// followed by a one-cycle IDLE bubble in which the next owner is chosen.
// A write is never issued while the FIFO reports full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  input  logic                         fifo_full_i,
  input  logic                         fifo_overflow_i,
  output logic                         fifo_wr_o,
  output logic [DATA_W-1:0]            fifo_data_o,
  output logic [$clog2(NUM_REQ)-1:0]   owner_o,
  output logic                         busy_o,
  output logic                         err_overflow_o,
  output logic [15:0]                  xfer_cnt_o
);

  localparam int OW_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [OW_W-1:0]   owner_q, owner_d;
  logic [BC_W-1:0]   burst_q, burst_d;
  logic [15:0]       xfer_q, xfer_d;
  logic              err_q;
  logic              xfer;
  logic [OW_W-1:0]   next_owner;
  logic              found;

  // Round-robin search starting just after the last owner, wrapping around.
  always_comb begin
    next_owner = owner_q;
    found      = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [OW_W-1:0] idx;
      idx = OW_W'((int'(owner_q) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        next_owner = idx;
      end
    end
  end

  // Write-side outputs are combinational from state so a beat lands in the same cycle.
  always_comb begin
    xfer        = (state_q == BURST) && req_i[owner_q] && !fifo_full_i;
    fifo_wr_o   = xfer;
    gnt_o       = xfer ? (NUM_REQ'(1) << owner_q) : '0;
    fifo_data_o = (state_q == BURST) ? req_data_i[int'(owner_q)*DATA_W +: DATA_W] : '0;
    busy_o      = (state_q == BURST);
  end

  // Next-state: pick an owner in IDLE, count beats and end the tenure in BURST.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    xfer_d  = xfer_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = next_owner;
          burst_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          burst_d = burst_q + BC_W'(1);
          xfer_d  = xfer_q + 16'd1;
        end
        // A full FIFO holds the tenure; only a dropped request or a last beat ends it.
        if (!req_i[owner_q]) begin
          state_d = IDLE;
        end else if (xfer && (burst_q == BC_W'(MAX_BURST - 1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; owner resets to the top index so the first grant searches from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OW_W'(NUM_REQ - 1);
      burst_q <= '0;
      xfer_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      xfer_q  <= xfer_d;
      if (fifo_overflow_i) begin
        err_q <= 1'b1;
      end
    end
  end

  assign owner_o        = owner_q;
  assign err_overflow_o = err_q;
  assign xfer_cnt_o     = xfer_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a vector table for single-producer,
// hand-over, full-stall and overflow behaviour, plus hand-written sequences
// for full contention and asynchronous reset in the middle of a tenure.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_i = '0;
  logic [31:0] req_data_i = '0;
  logic [3:0]  gnt_o;
  logic        fifo_full_i = 1'b0;
  logic        fifo_overflow_i = 1'b0;
  logic        fifo_wr_o;
  logic [7:0]  fifo_data_o;
  logic [1:0]  owner_o;
  logic        busy_o;
  logic        err_overflow_o;
  logic [15:0] xfer_cnt_o;

  int n_vec  = 0;
  int n_miss = 0;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_i           (req_i),
    .req_data_i      (req_data_i),
    .gnt_o           (gnt_o),
    .fifo_full_i     (fifo_full_i),
    .fifo_overflow_i (fifo_overflow_i),
    .fifo_wr_o       (fifo_wr_o),
    .fifo_data_o     (fifo_data_o),
    .owner_o         (owner_o),
    .busy_o          (busy_o),
    .err_overflow_o  (err_overflow_o),
    .xfer_cnt_o      (xfer_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  d1;
    logic        full;
    logic        ovf;
    logic [3:0]  gnt;
    logic        wr;
    logic [7:0]  data;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] xfer;
    logic        err;
  } vec_t;

  vec_t tbl[25];

  task automatic drive(input logic [3:0] r, input logic [7:0] d1,
                       input logic full, input logic ovf);
    req_i           = r;
    req_data_i      = {8'h40, 8'h30, d1, 8'h10};
    fifo_full_i     = full;
    fifo_overflow_i = ovf;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [3:0] gnt, input logic wr, input logic [7:0] data,
                       input logic [1:0] owner, input logic busy,
                       input logic [15:0] xfer, input logic err);
    logic [32:0] act, exp;
    act = {gnt_o, fifo_wr_o, fifo_data_o, owner_o, busy_o, xfer_cnt_o, err_overflow_o};
    exp = {gnt, wr, data, owner, busy, xfer, err};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got gnt=%b wr=%b data=%h owner=%0d busy=%b xfer=%0d err=%b, want gnt=%b wr=%b data=%h owner=%0d busy=%b xfer=%0d err=%b",
               name, idx, gnt_o, fifo_wr_o, fifo_data_o, owner_o, busy_o, xfer_cnt_o,
               err_overflow_o, gnt, wr, data, owner, busy, xfer, err);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    drive(4'b0000, 8'h00, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    // req, d1, full, ovf | gnt, wr, data, owner, busy, xfer, err
    tbl[0]  = '{4'b0010, 8'hA1, 0, 0, 4'b0000, 0, 8'h00, 2'd3, 0, 16'd0, 0};
    tbl[1]  = '{4'b0010, 8'hA1, 0, 0, 4'b0010, 1, 8'hA1, 2'd1, 1, 16'd0, 0};
    tbl[2]  = '{4'b0010, 8'hA2, 0, 0, 4'b0010, 1, 8'hA2, 2'd1, 1, 16'd1, 0};
    tbl[3]  = '{4'b0001, 8'hA2, 0, 0, 4'b0000, 0, 8'hA2, 2'd1, 1, 16'd2, 0};
    tbl[4]  = '{4'b0011, 8'hA2, 0, 0, 4'b0000, 0, 8'h00, 2'd1, 0, 16'd2, 0};
    tbl[5]  = '{4'b0011, 8'hA2, 0, 0, 4'b0001, 1, 8'h10, 2'd0, 1, 16'd2, 0};
    tbl[6]  = '{4'b0010, 8'hA2, 0, 0, 4'b0000, 0, 8'h10, 2'd0, 1, 16'd3, 0};
    tbl[7]  = '{4'b0010, 8'hA2, 0, 0, 4'b0000, 0, 8'h00, 2'd0, 0, 16'd3, 0};
    tbl[8]  = '{4'b0000, 8'hA2, 0, 0, 4'b0000, 0, 8'hA2, 2'd1, 1, 16'd3, 0};
    tbl[9]  = '{4'b0000, 8'hA2, 0, 0, 4'b0000, 0, 8'h00, 2'd1, 0, 16'd3, 0};
    tbl[10] = '{4'b0100, 8'hA2, 0, 0, 4'b0000, 0, 8'h00, 2'd1, 0, 16'd3, 0};
    tbl[11] = '{4'b0100, 8'hA2, 0, 0, 4'b0100, 1, 8'h30, 2'd2, 1, 16'd3, 0};
    tbl[12] = '{4'b0100, 8'hA2, 1, 0, 4'b0000, 0, 8'h30, 2'd2, 1, 16'd4, 0};
    tbl[13] = '{4'b0100, 8'hA2, 1, 0, 4'b0000, 0, 8'h30, 2'd2, 1, 16'd4, 0};
    tbl[14] = '{4'b0100, 8'hA2, 1, 0, 4'b0000, 0, 8'h30, 2'd2, 1, 16'd4, 0};
    tbl[15] = '{4'b0100, 8'hA2, 0, 0, 4'b0100, 1, 8'h30, 2'd2, 1, 16'd4, 0};
    tbl[16] = '{4'b0100, 8'hA2, 0, 0, 4'b0100, 1, 8'h30, 2'd2, 1, 16'd5, 0};
    tbl[17] = '{4'b0100, 8'hA2, 0, 0, 4'b0100, 1, 8'h30, 2'd2, 1, 16'd6, 0};
    tbl[18] = '{4'b0100, 8'hA2, 0, 0, 4'b0000, 0, 8'h00, 2'd2, 0, 16'd7, 0};
    tbl[19] = '{4'b0000, 8'hA2, 1, 0, 4'b0000, 0, 8'h30, 2'd2, 1, 16'd7, 0};
    tbl[20] = '{4'b0000, 8'hA2, 0, 0, 4'b0000, 0, 8'h00, 2'd2, 0, 16'd7, 0};
    tbl[21] = '{4'b1000, 8'hA2, 0, 1, 4'b0000, 0, 8'h00, 2'd2, 0, 16'd7, 0};
    tbl[22] = '{4'b1000, 8'hA2, 0, 1, 4'b1000, 1, 8'h40, 2'd3, 1, 16'd7, 1};
    tbl[23] = '{4'b0000, 8'hA2, 0, 0, 4'b0000, 0, 8'h40, 2'd3, 1, 16'd8, 1};
    tbl[24] = '{4'b0000, 8'hA2, 0, 0, 4'b0000, 0, 8'h00, 2'd3, 0, 16'd8, 1};

    // Reset state
    do_reset();
    #2 check("reset", 0, 4'b0000, 0, 8'h00, 2'd3, 0, 16'd0, 0);
    next_cycle();

    // Table: single producer, hand-over, full stall, req drop while full, overflow
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].req, tbl[i].d1, tbl[i].full, tbl[i].ovf);
      #2 check("table", i, tbl[i].gnt, tbl[i].wr, tbl[i].data, tbl[i].owner,
               tbl[i].busy, tbl[i].xfer, tbl[i].err);
      next_cycle();
    end

    // Asynchronous reset in the middle of an owner-3 tenure
    drive(4'b1000, 8'hA2, 1'b0, 1'b0);
    next_cycle();
    #2 check("rst_pre", 0, 4'b1000, 1, 8'h40, 2'd3, 1, 16'd8, 1);
    #1 rst = 1'b1;
    #1 check("rst_async", 0, 4'b0000, 0, 8'h00, 2'd3, 0, 16'd0, 0);
    next_cycle();
    rst = 1'b0;
    drive(4'b1001, 8'hA2, 1'b0, 1'b0);
    #2 check("rst_idle", 0, 4'b0000, 0, 8'h00, 2'd3, 0, 16'd0, 0);
    next_cycle();
    #2 check("rst_first", 0, 4'b0001, 1, 8'h10, 2'd0, 1, 16'd0, 0);
    next_cycle();

    // Full contention: 4-beat tenures separated by one idle bubble
    do_reset();
    drive(4'b1111, 8'h20, 1'b0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      logic [3:0] eg;
      logic [1:0] eo;
      logic [7:0] ed;
      eo = (c < 5) ? 2'd3 : 2'(((c - 1) / 5) % 4);
      if (c % 5 == 0) begin
        eg = 4'b0000;
        ed = 8'h00;
      end else begin
        eo = 2'((c / 5) % 4);
        eg = 4'(1) << eo;
        ed = 8'h10 + 8'(eo) * 8'h10;
      end
      #2 check("contend", c, eg, (c % 5 != 0), ed, eo, (c % 5 != 0),
               16'((c / 5) * 4 + ((c % 5 == 0) ? 0 : (c % 5) - 1)), 0);
      next_cycle();
    end
    drive(4'b0000, 8'h20, 1'b0, 1'b0);
    #2 check("contend_total", 0, 4'b0000, 0, 8'h00, 2'd3, 0, 16'd32, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
